// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register operand fetch sequencer: FSM states,
// register-file address width and default data/tag widths.
package reg_seq_pkg;

    localparam int REG_AW     = 4;
    localparam int DW_DEFAULT = 32;
    localparam int TW_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_D  = 3'd1,
        RD_P  = 3'd2,
        CAP_P = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    function automatic logic state_busy(input seq_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/RegDecoder.sv
// Expands the compact 4-bit operand field into the two register addresses.
// The D operand lives in the upper quarter, the P operand in the one below it.
module RegDecoder
    import reg_seq_pkg::*;
(
    input  logic [REG_AW-1:0] r,
    output logic [REG_AW-1:0] rd_addr,
    output logic [REG_AW-1:0] rp_addr
);

    // Prefixes 2'b11 and 2'b10 differ, so the two addresses can never collide.
    assign rd_addr = {2'b11, r[3:2]};
    assign rp_addr = {2'b10, r[1:0]};

endmodule

// File: rtl/reg_fetch_seq.sv
// Fetches a D/P operand pair from a register file for each request and
// presents it with its tag. Define RSEQ_WB_BYPASS_EN to forward write-back data.
module reg_fetch_seq
    import reg_seq_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int TW = TW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_r,
    input  logic [TW-1:0]     req_tag,
    output logic              rf_ren,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DW-1:0]     rf_rdata,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DW-1:0]     wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DW-1:0]     op_d,
    output logic [DW-1:0]     op_p,
    output logic [TW-1:0]     op_tag,
    output logic              busy
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [3:0]        r_q;
    logic [TW-1:0]     tag_q;
    logic [DW-1:0]     d_q;
    logic [DW-1:0]     p_q;
    logic [REG_AW-1:0] ext_rd;
    logic [REG_AW-1:0] ext_rp;
    logic [DW-1:0]     cap_data;
    logic              accept;

    RegDecoder u_dec (
        .r       (r_q),
        .rd_addr (ext_rd),
        .rp_addr (ext_rp)
    );

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RD_D;
            RD_D:    state_d = RD_P;
            RD_P:    state_d = CAP_P;
            CAP_P:   state_d = DONE;
            DONE: begin
                if (op_ready) begin
                    state_d = req_valid ? RD_D : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rf_ren    = 1'b0;
        rf_raddr  = '0;
        op_valid  = 1'b0;
        busy      = state_busy(state_q);
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD_D: begin
                rf_ren   = 1'b1;
                rf_raddr = ext_rd;
            end
            RD_P: begin
                rf_ren   = 1'b1;
                rf_raddr = ext_rp;
            end
            DONE: begin
                op_valid  = 1'b1;
                req_ready = op_ready;
            end
            default: ;
        endcase
    end

`ifdef RSEQ_WB_BYPASS_EN
    logic [REG_AW-1:0] cap_addr;
    logic              cap_hit;
    logic              done_hit_d;
    logic              done_hit_p;

    // The capture cycle compares against the address issued one cycle earlier.
    assign cap_addr   = (state_q == RD_P) ? ext_rd : ext_rp;
    assign cap_hit    = wb_we && (wb_addr == cap_addr);
    assign cap_data   = cap_hit ? wb_data : rf_rdata;
    assign done_hit_d = (state_q == DONE) && wb_we && (wb_addr == ext_rd);
    assign done_hit_p = (state_q == DONE) && wb_we && (wb_addr == ext_rp);
`else
    logic wb_unused;

    assign cap_data  = rf_rdata;
    assign wb_unused = ^{wb_we, wb_addr, wb_data};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            tag_q <= '0;
            d_q   <= '0;
            p_q   <= '0;
        end else begin
            if (accept) begin
                r_q   <= req_r;
                tag_q <= req_tag;
            end
            if (state_q == RD_P) begin
                d_q <= cap_data;
            end
            if (state_q == CAP_P) begin
                p_q <= cap_data;
            end
`ifdef RSEQ_WB_BYPASS_EN
            if (done_hit_d) begin
                d_q <= wb_data;
            end
            if (done_hit_p) begin
                p_q <= wb_data;
            end
`endif
        end
    end

    assign op_d   = d_q;
    assign op_p   = p_q;
    assign op_tag = tag_q;

endmodule

// File: tb/tb_reg_fetch_seq.sv
// Scoreboard bench for reg_fetch_seq: directed requests push expected operand
// pairs, a negedge monitor compares every presented pair against the queue.
module tb_reg_fetch_seq;

    localparam int DW = 32;
    localparam int TW = 3;

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] p;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_r;
    logic [TW-1:0] req_tag;
    logic          rf_ren;
    logic [3:0]    rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          wb_we;
    logic [3:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_d;
    logic [DW-1:0] op_p;
    logic [TW-1:0] op_tag;
    logic          busy;

    logic [DW-1:0] mem [16];
    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    reg_fetch_seq #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_r     (req_r),
        .req_tag   (req_tag),
        .rf_ren    (rf_ren),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_d      (op_d),
        .op_p      (op_p),
        .op_tag    (op_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register file model: one-cycle read latency, data held when not reading.
    always @(posedge clk) begin
        if (rf_ren) rf_rdata <= mem[rf_raddr];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [TW-1:0] tag,
                                 input logic [DW-1:0] ed, input logic [DW-1:0] ep,
                                 input bit expect_pair);
        int n = 0;
        exp_t e;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=req_ready 0 expected=1");
        end
        req_valid = 1'b1;
        req_r     = r;
        req_tag   = tag;
        if (expect_pair) begin
            e.d = ed; e.p = ep; e.tag = tag;
            sb.push_back(e);
        end
        step();
        req_valid = 1'b0;
    endtask

    // Monitor: every cycle op_valid is up, the presented pair must equal the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && op_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pair actual=d %0h p %0h expected=none", op_d, op_p);
            end else begin
                checkOutput("mon_op_d", op_d, sb[0].d);
                checkOutput("mon_op_p", op_p, sb[0].p);
                checkOutput("mon_op_tag", op_tag, sb[0].tag);
                if (op_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h5500_0000 + i;
        mem[4'hE] = 32'hAAAA_000E;
        mem[4'hA] = 32'hAAAA_000A;
        mem[4'hF] = 32'hBBBB_000F;
        mem[4'h8] = 32'hBBBB_0008;
        mem[4'hD] = 32'hCCCC_000D;
        mem[4'hC] = 32'hCCCC_000C;
        mem[4'hB] = 32'hCCCC_000B;
        rf_rdata  = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_r     = '0;
        req_tag   = '0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        op_ready  = 1'b1;

        step(); step();
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_op_valid", op_valid, 0);
        checkOutput("rst_rf_ren", rf_ren, 0);
        checkOutput("rst_rf_raddr", rf_raddr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_op_d", op_d, 0);
        checkOutput("rst_op_p", op_p, 0);
        checkOutput("rst_op_tag", op_tag, 0);
        rst_n = 1'b1;
        step();

        // Basic fetch of E/A with 4-cycle latency
        applyStimulus(4'b1010, 3'd2, 32'hAAAA_000E, 32'hAAAA_000A, 1'b1);
        checkOutput("t1_c1_ren", rf_ren, 1);
        checkOutput("t1_c1_raddr", rf_raddr, 4'hE);
        checkOutput("t1_c1_busy", busy, 1);
        checkOutput("t1_c1_req_ready", req_ready, 0);
        step();
        checkOutput("t1_c2_ren", rf_ren, 1);
        checkOutput("t1_c2_raddr", rf_raddr, 4'hA);
        step();
        checkOutput("t1_c3_ren", rf_ren, 0);
        checkOutput("t1_c3_raddr", rf_raddr, 0);
        checkOutput("t1_c3_op_valid", op_valid, 0);
        step();
        checkOutput("t1_c4_op_valid", op_valid, 1);
        checkOutput("t1_c4_raddr", rf_raddr, 0);
        step();
        checkOutput("t1_idle_busy", busy, 0);

        // Stall in DONE for three cycles
        op_ready = 1'b0;
        applyStimulus(4'b1100, 3'd5, 32'hBBBB_000F, 32'hBBBB_0008, 1'b1);
        checkOutput("t2_c1_raddr", rf_raddr, 4'hF);
        step();
        checkOutput("t2_c2_raddr", rf_raddr, 4'h8);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_stall_valid", op_valid, 1);
            checkOutput("t2_stall_req_ready", req_ready, 0);
            checkOutput("t2_stall_busy", busy, 1);
            if (i < 2) step();
        end
        step();
        op_ready = 1'b1;
        checkOutput("t2_release_valid", op_valid, 1);
        step();
        checkOutput("t2_after_valid", op_valid, 0);

        // Back-to-back: second request taken in the DONE cycle of the first
        applyStimulus(4'b0110, 3'd1, 32'hCCCC_000D, 32'hAAAA_000A, 1'b1);
        checkOutput("t3a_raddr", rf_raddr, 4'hD);
        step(); step(); step();
        checkOutput("t3_done_valid", op_valid, 1);
        checkOutput("t3_done_req_ready", req_ready, 1);
        applyStimulus(4'b0011, 3'd6, 32'hCCCC_000C, 32'hCCCC_000B, 1'b1);
        checkOutput("t3b_ren", rf_ren, 1);
        checkOutput("t3b_raddr", rf_raddr, 4'hC);
        checkOutput("t3b_busy", busy, 1);
        step();
        checkOutput("t3b_c2_raddr", rf_raddr, 4'hB);
        step(); step();
        checkOutput("t3b_c4_valid", op_valid, 1);
        step();

        // Reset during RD_P abandons the fetch
        applyStimulus(4'b0101, 3'd3, 32'h0, 32'h0, 1'b0);
        step();
        checkOutput("t4_in_rdp_raddr", rf_raddr, 4'h9);
        rst_n = 1'b0;
        step();
        checkOutput("t4_ren", rf_ren, 0);
        checkOutput("t4_op_valid", op_valid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_req_ready", req_ready, 1);
        checkOutput("t4_op_d", op_d, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checkOutput("t4_still_idle", busy, 0);

        // Write-back coinciding with the D capture cycle
`ifdef RSEQ_WB_BYPASS_EN
        applyStimulus(4'b1010, 3'd7, 32'h1234_5678, 32'hAAAA_000A, 1'b1);
`else
        applyStimulus(4'b1010, 3'd7, 32'hAAAA_000E, 32'hAAAA_000A, 1'b1);
`endif
        step();
        wb_we   = 1'b1;
        wb_addr = 4'hE;
        wb_data = 32'h1234_5678;
        step();
        wb_we   = 1'b0;
        step();
        checkOutput("t5_valid", op_valid, 1);
        step();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checkOutput("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
